disp_share_arb: RTL and testbench

Arbitrates the 4-digit time-multiplexed 7-segment display between two requesters (for example, a status/counter client and a debug/switch client). Each requester presents a 16-bit hex value plus 4 decimal-point flags. The block grants the display round-robin with a minimum hold time and hex-encodes the owner's value into the four 8-bit segment patterns. Its outputs drive the in0..in3 inputs of disp_mux directly. When no requester is active, it drives blank patterns.

---
 rtl/disp_share_arb.sv | 195 +++++++++++++++++++
 tb/tb_disp_share_arb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/disp_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : disp_share_arb
//  Purpose  : Shares the 4-digit multiplexed 7-segment display between two
//             requesters. Ownership is granted round-robin with a minimum
//             hold time, and the owner's 16-bit hex value is encoded into
//             four active-low segment patterns for disp_mux.
//  Ports    :
//    clk          - system clock
//    reset        - synchronous, active-high reset
//    req[1:0]     - req[i] high = requester i wants the display
//    val0, val1   - requester hex values, [3:0] is digit 0 (rightmost)
//    dp0, dp1     - requester decimal points, bit i lights digit i
//    gnt[1:0]     - one-hot grant, 2'b00 when idle
//    in0..in3     - digit 0..3 segment patterns {~dp, g..a}, active-low
//    switch_p     - one-cycle pulse aligned with every change of gnt
//  Revision : 1.0  initial release
// ============================================================================
module disp_share_arb #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    input  logic [3:0]  dp0,
    input  logic [3:0]  dp1,
    output logic [1:0]  gnt,
    output logic [7:0]  in0,
    output logic [7:0]  in1,
    output logic [7:0]  in2,
    output logic [7:0]  in3,
    output logic        switch_p
);

    localparam logic [CNT_W-1:0] c_HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // State encoding doubles as the grant vector.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_OWN0 = 2'b01,
        S_OWN1 = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              switch_q;
    logic [3:0][7:0]   dig_q;
    logic [3:0][7:0]   dig_d;

    logic              w_hold_done;
    logic              w_state_chg;
    logic [15:0]       w_val;
    logic [3:0]        w_dp;
    logic              w_idle;

    // Hex digit to segments g..a, active-low.
    function automatic logic [6:0] seg7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign w_hold_done = (cnt_q == c_HOLD_MAX);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                case (req)
                    2'b01:   state_d = S_OWN0;
                    2'b10:   state_d = S_OWN1;
                    // Tie goes to whoever was not served most recently.
                    2'b11:   state_d = last_q ? S_OWN0 : S_OWN1;
                    default: state_d = S_IDLE;
                endcase
            end
            S_OWN0: begin
                if (!req[0]) begin
                    state_d = req[1] ? S_OWN1 : S_IDLE;
                end else if (req[1] && w_hold_done) begin
                    state_d = S_OWN1;
                end
            end
            S_OWN1: begin
                if (!req[1]) begin
                    state_d = req[0] ? S_OWN0 : S_IDLE;
                end else if (req[0] && w_hold_done) begin
                    state_d = S_OWN0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign w_state_chg = (state_d != state_q);

    always_comb begin
        last_d = last_q;
        if (state_d == S_OWN0) begin
            last_d = 1'b0;
        end else if (state_d == S_OWN1) begin
            last_d = 1'b1;
        end
    end

    // Counter saturates so a long-running sole owner yields at once when
    // the other side finally asks.
    always_comb begin
        cnt_d = cnt_q;
        if (w_state_chg || (state_q == S_IDLE)) begin
            cnt_d = '0;
        end else if (!w_hold_done) begin
            cnt_d = cnt_q + c_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Output datapath: patterns follow the current owner, so they land one
    // edge after the grant that selects them.
    // ------------------------------------------------------------------
    always_comb begin
        w_val  = 16'h0000;
        w_dp   = 4'h0;
        w_idle = 1'b0;
        case (state_q)
            S_OWN0: begin
                w_val = val0;
                w_dp  = dp0;
            end
            S_OWN1: begin
                w_val = val1;
                w_dp  = dp1;
            end
            default: w_idle = 1'b1;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        assign dig_d[gi] = w_idle ? 8'hFF
                                  : {~w_dp[gi], seg7(w_val[gi*4 +: 4])};
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            switch_q <= 1'b0;
            dig_q    <= {4{8'hFF}};
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            switch_q <= w_state_chg;
            dig_q    <= dig_d;
        end
    end

    assign gnt      = state_q;
    assign switch_p = switch_q;
    assign in0      = dig_q[0];
    assign in1      = dig_q[1];
    assign in2      = dig_q[2];
    assign in3      = dig_q[3];

endmodule
`default_nettype wire

// File: tb/tb_disp_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_disp_share_arb
//  Purpose  : Self-checking bench for disp_share_arb with HOLD_CYCLES = 4.
//             A cycle-by-cycle vector table drives reset/req/val0/dp0 and
//             lists the expected grant, switch pulse and digit patterns
//             after each rising edge; hand-written sequences follow for the
//             long hold and late-arrival cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_disp_share_arb;

    localparam int HOLD_CYCLES = 4;
    localparam int CNT_W       = 3;

    // Expected {in3,in2,in1,in0} words, hand-encoded.
    localparam logic [31:0] c_BLANK = 32'hFFFF_FFFF;
    localparam logic [31:0] c_V0P   = 32'hB008_F88E;   // 3A7F, dp0=0100
    localparam logic [31:0] c_V1P   = 32'h8692_A179;   // E5D1, dp1=0001
    localparam logic [15:0] c_V0    = 16'h3A7F;
    localparam logic [3:0]  c_D0    = 4'b0100;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] val0;
    logic [15:0] val1;
    logic [3:0]  dp0;
    logic [3:0]  dp1;
    logic [1:0]  gnt;
    logic [7:0]  in0, in1, in2, in3;
    logic        switch_p;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [15:0] v0;
        logic [3:0]  d0;
        logic [1:0]  gnt;
        logic        sw;
        logic [31:0] dig;
    } vec_t;

    vec_t vecs[$];

    disp_share_arb #(
        .HOLD_CYCLES(HOLD_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .val0    (val0),
        .val1    (val1),
        .dp0     (dp0),
        .dp1     (dp1),
        .gnt     (gnt),
        .in0     (in0),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .switch_p(switch_p)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [1:0] rq, input logic [15:0] v,
                       input logic [3:0] d, input logic [1:0] g, input logic s,
                       input logic [31:0] dg);
        vec_t t;
        t.rst = r; t.req = rq; t.v0 = v; t.d0 = d;
        t.gnt = g; t.sw = s;   t.dig = dg;
        vecs.push_back(t);
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic apply(input logic r, input logic [1:0] rq,
                         input logic [15:0] v, input logic [3:0] d);
        @(negedge clk);
        reset = r;
        req   = rq;
        val0  = v;
        dp0   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] g,
                         input logic s, input logic [31:0] dg);
        logic [31:0] act;
        act = {in3, in2, in1, in0};
        n_vec++;
        if (gnt !== g || switch_p !== s || act !== dg || gnt === 2'b11) begin
            n_miss++;
            $display("FAIL %s: got gnt=%b sw=%b dig=%h, want gnt=%b sw=%b dig=%h",
                     name, gnt, switch_p, act, g, s, dg);
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 2'b00;
        val0  = c_V0;
        dp0   = c_D0;
        val1  = 16'hE5D1;
        dp1   = 4'b0001;

        // rst req  val0      dp0      gnt    sw  digits
        // Reset held with both requesting.
        add(1, 2'b11, c_V0, c_D0, 2'b00, 0, c_BLANK);
        add(1, 2'b11, c_V0, c_D0, 2'b00, 0, c_BLANK);
        add(1, 2'b11, c_V0, c_D0, 2'b00, 0, c_BLANK);
        // Release: requester 0 wins the tie; patterns follow one edge later.
        add(0, 2'b11, c_V0, c_D0, 2'b01, 1, c_BLANK);
        add(0, 2'b11, c_V0, c_D0, 2'b01, 0, c_V0P);
        add(0, 2'b11, c_V0, c_D0, 2'b01, 0, c_V0P);
        add(0, 2'b11, c_V0, c_D0, 2'b01, 0, c_V0P);
        // Hold expired -> OWN1.
        add(0, 2'b11, c_V0, c_D0, 2'b10, 1, c_V0P);
        add(0, 2'b11, c_V0, c_D0, 2'b10, 0, c_V1P);
        add(0, 2'b11, c_V0, c_D0, 2'b10, 0, c_V1P);
        add(0, 2'b11, c_V0, c_D0, 2'b10, 0, c_V1P);
        // Back to OWN0 after 4 cycles.
        add(0, 2'b11, c_V0, c_D0, 2'b01, 1, c_V1P);
        add(0, 2'b11, c_V0, c_D0, 2'b01, 0, c_V0P);
        add(0, 2'b11, c_V0, c_D0, 2'b01, 0, c_V0P);
        add(0, 2'b11, c_V0, c_D0, 2'b01, 0, c_V0P);
        add(0, 2'b11, c_V0, c_D0, 2'b10, 1, c_V0P);
        add(0, 2'b11, c_V0, c_D0, 2'b10, 0, c_V1P);   // OWN1, cnt=1
        // Early release of req1 -> straight to requester 0.
        add(0, 2'b01, c_V0, c_D0, 2'b01, 1, c_V1P);
        add(0, 2'b01, c_V0, c_D0, 2'b01, 0, c_V0P);
        // Drop both -> IDLE, blank one edge later.
        add(0, 2'b00, c_V0, c_D0, 2'b00, 1, c_V0P);
        add(0, 2'b00, c_V0, c_D0, 2'b00, 0, c_BLANK);
        // One-cycle pulse on req1 still grants one cycle.
        add(0, 2'b10, c_V0, c_D0, 2'b10, 1, c_BLANK);
        add(0, 2'b00, c_V0, c_D0, 2'b00, 1, c_V1P);
        add(0, 2'b00, c_V0, c_D0, 2'b00, 0, c_BLANK);
        // Tie after serving 1 -> requester 0.
        add(0, 2'b11, c_V0, c_D0, 2'b01, 1, c_BLANK);
        // Hex/dp encoding, live tracking of val0 (sole requester 0).
        add(0, 2'b01, c_V0,     c_D0,    2'b01, 0, c_V0P);
        add(0, 2'b01, 16'h0123, 4'b0000, 2'b01, 0, 32'hC0F9_A4B0);
        add(0, 2'b01, 16'h4567, 4'b1111, 2'b01, 0, 32'h1912_0278);
        add(0, 2'b01, 16'h89AB, 4'b1010, 2'b01, 0, 32'h0090_0883);
        add(0, 2'b01, 16'hCDEF, 4'b0101, 2'b01, 0, 32'hC621_860E);
        add(0, 2'b01, c_V0,     c_D0,    2'b01, 0, c_V0P);
        // Saturated counter: req1 arrives, switch on the first edge.
        add(0, 2'b11, c_V0, c_D0, 2'b10, 1, c_V0P);
        add(0, 2'b11, c_V0, c_D0, 2'b10, 0, c_V1P);
        // One-cycle reset mid-ownership: no switch pulse, blank at once.
        add(1, 2'b11, c_V0, c_D0, 2'b00, 0, c_BLANK);
        // last reset to 1 -> requester 0 granted.
        add(0, 2'b11, c_V0, c_D0, 2'b01, 1, c_BLANK);
        add(0, 2'b11, c_V0, c_D0, 2'b01, 0, c_V0P);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].req, vecs[i].v0, vecs[i].d0);
            check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sw, vecs[i].dig);
        end

        // Sole requester 0 keeps the display for 20 cycles, no switch.
        apply(1'b1, 2'b00, c_V0, c_D0);
        check("seq_reset", 2'b00, 1'b0, c_BLANK);
        apply(1'b0, 2'b01, c_V0, c_D0);
        check("seq_grant0", 2'b01, 1'b1, c_BLANK);
        for (int k = 0; k < 20; k++) begin
            apply(1'b0, 2'b01, c_V0, c_D0);
            check($sformatf("seq_hold%0d", k), 2'b01, 1'b0, c_V0P);
        end
        // Late arrival on a saturated counter.
        apply(1'b0, 2'b11, c_V0, c_D0);
        check("seq_late", 2'b10, 1'b1, c_V0P);
        apply(1'b0, 2'b11, c_V0, c_D0);
        check("seq_late_dig", 2'b10, 1'b0, c_V1P);
        // Sole requester 1 likewise holds past the hold time.
        for (int k = 0; k < 6; k++) begin
            apply(1'b0, 2'b10, c_V0, c_D0);
            check($sformatf("seq_own1_%0d", k), 2'b10, 1'b0, c_V1P);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
